mpc_div_seq_35s_14s_21: RTL

//  Sequential signed integer divider; the inverse of the 21s x 14s -> 35 MPC multiplier.

---
 rtl/mpc_div_seq_35s_14s_21.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mpc_div_seq_35s_14s_21.sv
// Sequential signed divider: 35-bit signed dividend by 14-bit signed divisor,
// producing a saturated 21-bit signed quotient and a dividend-signed remainder.
// Radix-2 restoring division on magnitudes, one quotient bit per enabled cycle.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   ce            clock enable, freezes every register when low
//   start         request, accepted only while ready
//   din0, din1    dividend / divisor, captured on an accepted start
//   ready         idle and able to accept start
//   done          one ce-qualified cycle pulse, results valid
//   dout, rem     quotient (truncated toward zero, saturated) and remainder
//   ovf, div0     quotient clipped or divisor zero / divisor zero
module mpc_div_seq_35s_14s_21 #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 35,
  parameter int unsigned din1_WIDTH = 14,
  parameter int unsigned dout_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  div0
);

  localparam int unsigned DW0 = din0_WIDTH;
  localparam int unsigned DW1 = din1_WIDTH;
  localparam int unsigned DOW = dout_WIDTH;
  // ID is an instance tag only; folded in here so it is referenced.
  localparam int unsigned CW  = $clog2(DW0) + (ID * 0);

  // Quotient magnitude limits and saturated output codes
  localparam logic [DW0-1:0] NEG_LIM  = DW0'(1) << (DOW - 1);
  localparam logic [DW0-1:0] POS_LIM  = NEG_LIM - DW0'(1);
  localparam logic [DOW-1:0] DOUT_MIN = DOW'(1) << (DOW - 1);
  localparam logic [DOW-1:0] DOUT_MAX = ~DOUT_MIN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [DW0-1:0] a_q, a_d;
  logic [DW1-1:0] b_q, b_d;
  logic [DW0-1:0] quo_q, quo_d;
  logic [DW1-1:0] dsr_q, dsr_d;
  logic [DW1:0]   prem_q, prem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           dneg_q, dneg_d;
  logic           zero_q, zero_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic [DOW-1:0] dout_q, dout_d;
  logic [DW1-1:0] rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic           div0_q, div0_d;

  logic [DW1:0]   shifted;
  logic [DW1+1:0] diff;
  logic           over;
  logic [DOW-1:0] q_lo;
  logic [DOW-1:0] q_signed;
  logic [DW1-1:0] r_mag;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    prem_d   = prem_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dneg_d   = dneg_q;
    zero_d   = zero_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    div0_d   = div0_q;

    // Restoring step: the quotient register doubles as the dividend shifter
    shifted  = {prem_q[DW1-1:0], quo_q[DW0-1]};
    diff     = {1'b0, shifted} - {2'b00, dsr_q};

    // Sign application and saturation of the finished magnitudes
    over     = neg_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);
    q_lo     = quo_q[DOW-1:0];
    q_signed = neg_q ? DOW'(~q_lo + DOW'(1)) : q_lo;
    r_mag    = prem_q[DW1-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = din0;
          b_d     = din1;
          ready_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        dneg_d  = a_q[DW0-1];
        neg_d   = a_q[DW0-1] ^ b_q[DW1-1];
        quo_d   = a_q[DW0-1] ? DW0'(~a_q + DW0'(1)) : a_q;
        dsr_d   = b_q[DW1-1] ? DW1'(~b_q + DW1'(1)) : b_q;
        zero_d  = (b_q == '0);
        prem_d  = '0;
        cnt_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (!diff[DW1+1]) begin
          prem_d = diff[DW1:0];
          quo_d  = {quo_q[DW0-2:0], 1'b1};
        end else begin
          prem_d = shifted;
          quo_d  = {quo_q[DW0-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW0 - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (zero_q) begin
          dout_d = dneg_q ? DOUT_MIN : DOUT_MAX;
          rem_d  = '0;
          ovf_d  = 1'b1;
          div0_d = 1'b1;
        end else begin
          dout_d = over ? (neg_q ? DOUT_MIN : DOUT_MAX) : q_signed;
          rem_d  = dneg_q ? DW1'(~r_mag + DW1'(1)) : r_mag;
          ovf_d  = over;
          div0_d = 1'b0;
        end
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register; reset outranks ce
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      zero_q  <= zero_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;
  assign ovf   = ovf_q;
  assign div0  = div0_q;

endmodule
